seq_left_logic_shifter: RTL

//   Multi-cycle left logical shifter (SLL/SLLI) for the ALU slow path: shifts operator_1 left by

---
 rtl/shifter_pkg.sv | 11 +
 rtl/seq_left_logic_shifter_if.sv | 35 +++
 rtl/left_shift_step.sv | 21 ++
 rtl/seq_left_logic_shifter.sv | 103 ++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared constants and FSM state type for the sequential left shifter.
package shifter_pkg;
  localparam int XLEN    = 32;
  localparam int SHAMT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } shift_state_t;
endpackage

// File: rtl/seq_left_logic_shifter_if.sv
// Request/response bundle for seq_left_logic_shifter; the rotate request bit
// exists only when LSHIFT_ROTATE_EN is defined.
interface seq_left_logic_shifter_if;
  import shifter_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    operator_1;
  logic [SHAMT_W-1:0] operator_2;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    answer;

`ifdef LSHIFT_ROTATE_EN
  logic               rotate;

  modport master (
    output in_valid, operator_1, operator_2, rotate, out_ready,
    input  in_ready, out_valid, answer
  );
  modport slave (
    input  in_valid, operator_1, operator_2, rotate, out_ready,
    output in_ready, out_valid, answer
  );
`else
  modport master (
    output in_valid, operator_1, operator_2, out_ready,
    input  in_ready, out_valid, answer
  );
  modport slave (
    input  in_valid, operator_1, operator_2, out_ready,
    output in_ready, out_valid, answer
  );
`endif
endinterface

// File: rtl/left_shift_step.sv
// One combinational shift step: data shifted left by k (k <= STEP), vacated
// LSBs zero-filled, or filled with the bits shifted out when rotate is set.
module left_shift_step
  import shifter_pkg::*;
#(
  parameter int STEP = 1,
  parameter int KW   = $clog2(STEP + 1)
) (
  input  logic [XLEN-1:0] data,
  input  logic [KW-1:0]   k,
  input  logic            rotate,
  output logic [XLEN-1:0] result
);
  logic [XLEN-1:0] wrapped;

  always_comb begin
    // k == 0 must not wrap the whole word back in, so it is excluded explicitly.
    wrapped = (rotate && (k != '0)) ? (data >> (XLEN - int'(k))) : '0;
    result  = (data << k) | wrapped;
  end
endmodule

// File: rtl/seq_left_logic_shifter.sv
// Multi-cycle left logical shifter, STEP bit positions per cycle, with
// valid/ready on both sides. LSHIFT_ROTATE_EN adds a rotate-left request bit.
module seq_left_logic_shifter
  import shifter_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  seq_left_logic_shifter_if.slave  bus
);
  localparam int KW = $clog2(STEP + 1);

  shift_state_t       state_q, state_d;
  logic [XLEN-1:0]    data_q, data_d;
  logic [XLEN-1:0]    answer_q, answer_d;
  logic [SHAMT_W-1:0] remaining_q, remaining_d;
  logic [SHAMT_W-1:0] rest;
  logic [KW-1:0]      k;
  logic               rotate_q, rotate_d;
  logic               rotate_req;
  logic [XLEN-1:0]    stepped;

`ifdef LSHIFT_ROTATE_EN
  assign rotate_req = bus.rotate;
`else
  assign rotate_req = 1'b0;
`endif

  assign k    = (remaining_q > SHAMT_W'(STEP)) ? KW'(STEP) : KW'(remaining_q);
  assign rest = remaining_q - SHAMT_W'(k);

  left_shift_step #(
    .STEP (STEP),
    .KW   (KW)
  ) u_step (
    .data   (data_q),
    .k      (k),
    .rotate (rotate_q),
    .result (stepped)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    data_d        = data_q;
    remaining_d   = remaining_q;
    answer_d      = answer_q;
    rotate_d      = rotate_q;
    bus.in_ready  = (state_q == IDLE) && !rst;
    bus.out_valid = (state_q == DONE);
    bus.answer    = answer_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          data_d      = bus.operator_1;
          remaining_d = bus.operator_2;
          rotate_d    = rotate_req;
          if (bus.operator_2 == '0) begin
            state_d  = DONE;
            answer_d = bus.operator_1;
          end else begin
            state_d  = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d      = stepped;
        remaining_d = rest;
        if (rest == '0) begin
          state_d  = DONE;
          answer_d = stepped;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The published answer lives in its own register so it survives the
  // working register being reloaded by the next request.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= '0;
      answer_q    <= '0;
      remaining_q <= '0;
      rotate_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      answer_q    <= answer_d;
      remaining_q <= remaining_d;
      rotate_q    <= rotate_d;
    end
  end
endmodule
